// File: rtl/ranger_poll_ctrl.sv
// ranger_poll_ctrl: rangefinder measurement scheduler.
// Sends the command, waits for a reply with timeout/retry, polls.
module ranger_poll_ctrl #(
    parameter int          CMD_BYTES   = 4,
    parameter logic [31:0] CMD_WORD    = 32'h80060278,
    parameter int          PERIOD_CYC  = 50_000_000,
    parameter int          TIMEOUT_CYC = 25_000_000,
    parameter int          MAX_RETRY   = 3
) (
    input  logic       Clk,
    input  logic       RstN,
    input  logic       Enable,
    input  logic       Trigger,
    output logic       TxValid,
    output logic [7:0] TxData,
    input  logic       TxReady,
    input  logic       RxFrameEn,
    output logic       DecDataEn,
    output logic       Busy,
    output logic       MeasOk,
    output logic       MeasErr,
    output logic [1:0] RetryCnt,
    output logic [7:0] ErrCnt
);

    localparam int TW = ($clog2(TIMEOUT_CYC) > 0) ?
                        $clog2(TIMEOUT_CYC) : 1;
    localparam int PC = $clog2(PERIOD_CYC) + 1;
    localparam int PW = (PC > 26) ? PC : 26;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);
    localparam logic [1:0]    IDX_LAST = 2'(CMD_BYTES - 1);
    localparam logic [1:0]    MAX_R    = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_RX,
        HOLD,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [PW-1:0] per_q, per_d;
    logic          rx_prev_q, rx_prev_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          dec_q, dec_d;
    logic          busy_q, busy_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic          rx_rise;

    function automatic logic [7:0] cmd_byte(input logic [1:0] i);
        logic [7:0] b;
        unique case (i)
            2'd0: b = CMD_WORD[31:24];
            2'd1: b = CMD_WORD[23:16];
            2'd2: b = CMD_WORD[15:8];
            2'd3: b = CMD_WORD[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        per_d     = (per_q == '1) ? per_q : per_q + PW'(1);
        rx_prev_d = RxFrameEn;
        err_cnt_d = err_cnt_q;
        dec_d     = 1'b0;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        rx_rise   = RxFrameEn && !rx_prev_q;

        case (state_q)
            IDLE: begin
                if (Trigger || Enable) begin
                    state_d = SEND;
                    idx_d   = 2'd0;
                    retry_d = 2'd0;
                    per_d   = '0;
                end
            end
            SEND: begin
                if (TxReady) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = WAIT_RX;
                        tmo_d   = '0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            WAIT_RX: begin
                if (rx_rise) begin
                    state_d = HOLD;
                    dec_d   = 1'b1;
                    ok_d    = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    if (retry_q < MAX_R) begin
                        retry_d = retry_q + 2'd1;
                        idx_d   = 2'd0;
                        state_d = SEND;
                    end else begin
                        err_d   = 1'b1;
                        state_d = GAP;
                        if (err_cnt_q != 8'hff) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            HOLD: begin
                if (RxFrameEn) begin
                    dec_d = 1'b1;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (!Enable) begin
                    state_d = IDLE;
                end else if (per_q >= PER_LAST) begin
                    state_d = SEND;
                    idx_d   = 2'd0;
                    retry_d = 2'd0;
                    per_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        tx_valid_d = (state_d == SEND);
        tx_data_d  = tx_valid_d ? cmd_byte(idx_d) : 8'h00;
        busy_d     = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            retry_q    <= 2'd0;
            tmo_q      <= '0;
            per_q      <= '0;
            rx_prev_q  <= 1'b0;
            err_cnt_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            dec_q      <= 1'b0;
            busy_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            per_q      <= per_d;
            rx_prev_q  <= rx_prev_d;
            err_cnt_q  <= err_cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            dec_q      <= dec_d;
            busy_q     <= busy_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    assign TxValid   = tx_valid_q;
    assign TxData    = tx_data_q;
    assign DecDataEn = dec_q;
    assign Busy      = busy_q;
    assign MeasOk    = ok_q;
    assign MeasErr   = err_q;
    assign RetryCnt  = retry_q;
    assign ErrCnt    = err_cnt_q;

endmodule

// File: tb/tb_ranger_poll_ctrl.sv
// tb_ranger_poll_ctrl: directed bench with a procedural model.
// A second instance with tiny timing exercises ErrCnt saturation.
module tb_ranger_poll_ctrl;

    localparam int          NB   = 4;
    localparam logic [31:0] CMD  = 32'h80060278;
    localparam int          PER  = 1000;
    localparam int          TMO  = 100;
    localparam int          MAXR = 3;

    logic       Clk, RstN, Enable, Trigger, TxReady;
    logic       rx_man, rx_auto;
    wire        rx_frame_en = rx_man | rx_auto;
    logic       TxValid, DecDataEn, Busy, MeasOk, MeasErr;
    logic [7:0] TxData, ErrCnt;
    logic [1:0] RetryCnt;

    logic       s_en;
    logic       s_valid, s_dec, s_busy, s_ok, s_err;
    logic [7:0] s_data, s_errcnt;
    logic [1:0] s_retry;

    int n_chk = 0;
    int n_fail = 0;

    ranger_poll_ctrl #(
        .CMD_BYTES(NB), .CMD_WORD(CMD), .PERIOD_CYC(PER),
        .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)
    ) u_dut (
        .Clk(Clk), .RstN(RstN), .Enable(Enable),
        .Trigger(Trigger), .TxValid(TxValid), .TxData(TxData),
        .TxReady(TxReady), .RxFrameEn(rx_frame_en),
        .DecDataEn(DecDataEn), .Busy(Busy), .MeasOk(MeasOk),
        .MeasErr(MeasErr), .RetryCnt(RetryCnt), .ErrCnt(ErrCnt)
    );

    ranger_poll_ctrl #(
        .CMD_BYTES(1), .CMD_WORD(CMD), .PERIOD_CYC(8),
        .TIMEOUT_CYC(4), .MAX_RETRY(0)
    ) u_sat (
        .Clk(Clk), .RstN(RstN), .Enable(s_en),
        .Trigger(1'b0), .TxValid(s_valid), .TxData(s_data),
        .TxReady(1'b1), .RxFrameEn(1'b0),
        .DecDataEn(s_dec), .Busy(s_busy), .MeasOk(s_ok),
        .MeasErr(s_err), .RetryCnt(s_retry), .ErrCnt(s_errcnt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    // Procedural model: walks the measurement as a story.
    logic       e_valid, e_busy, e_dec, e_ok, e_err;
    logic [7:0] e_data, e_errcnt;
    logic [1:0] e_retry;
    int         m_per;
    bit         model_on = 1'b1;

    task automatic tick();
        @(posedge Clk);
        m_per++;
        e_ok = 1'b0;
        e_err = 1'b0;
    endtask

    task automatic model_meas();
        int retry;
        int b;
        bit got, stale;
        m_per = 0;
        forever begin
            retry = 0;
            e_retry = 2'd0;
            e_busy = 1'b1;
            got = 1'b0;
            forever begin
                b = 0;
                while (b < NB) begin
                    e_valid = 1'b1;
                    e_data = CMD[31-8*b -: 8];
                    tick();
                    if (TxReady) b++;
                end
                e_valid = 1'b0;
                e_data = 8'h00;
                stale = rx_frame_en;
                for (int t = 0; t < TMO; t++) begin
                    tick();
                    if (rx_frame_en && !stale) begin
                        got = 1'b1;
                        break;
                    end
                    if (!rx_frame_en) stale = 1'b0;
                end
                if (got || retry == MAXR) break;
                retry++;
                e_retry = 2'(retry);
            end
            if (got) begin
                e_ok = 1'b1;
                e_dec = 1'b1;
                do tick(); while (rx_frame_en);
                e_dec = 1'b0;
            end else begin
                e_err = 1'b1;
                if (e_errcnt != 8'd255) e_errcnt++;
            end
            forever begin
                tick();
                if (!Enable) begin
                    e_busy = 1'b0;
                    return;
                end
                if (m_per >= PER) break;
            end
            m_per = 0;
        end
    endtask

    initial begin
        e_valid = 0; e_busy = 0; e_dec = 0; e_ok = 0; e_err = 0;
        e_data = 0; e_errcnt = 0; e_retry = 0; m_per = 0;
        wait (RstN === 1'b1);
        forever begin
            tick();
            if (Trigger || Enable) model_meas();
        end
    end

    // Compare every output against the model each cycle.
    always @(negedge Clk) begin
        if (model_on && RstN === 1'b1) begin
            chk("TxValid", 32'(TxValid), 32'(e_valid));
            chk("TxData", 32'(TxData), 32'(e_data));
            chk("DecDataEn", 32'(DecDataEn), 32'(e_dec));
            chk("Busy", 32'(Busy), 32'(e_busy));
            chk("MeasOk", 32'(MeasOk), 32'(e_ok));
            chk("MeasErr", 32'(MeasErr), 32'(e_err));
            chk("RetryCnt", 32'(RetryCnt), 32'(e_retry));
            chk("ErrCnt", 32'(ErrCnt), 32'(e_errcnt));
        end
    end

    // Event monitor for literal checks.
    logic [7:0] byte_q[$];
    int         hs_q[$];
    int         starts[$];
    int         cyc_no = 0;
    int         ok_cnt = 0;
    int         err_cnt = 0;
    int         dec_hi = 0;
    int         s_errs = 0;
    logic       vprev = 1'b0;

    always @(posedge Clk) begin
        cyc_no++;
        if (RstN === 1'b1) begin
            if (TxValid && TxReady) begin
                byte_q.push_back(TxData);
                hs_q.push_back(cyc_no);
            end
            if (TxValid && !vprev) starts.push_back(cyc_no);
            vprev = TxValid;
            if (MeasOk) ok_cnt++;
            if (MeasErr) err_cnt++;
            if (DecDataEn) dec_hi++;
            if (s_err) begin
                s_errs++;
                chk("sat_errcnt_step", 32'(s_errcnt),
                    (s_errs > 255) ? 32'd255 : 32'(s_errs));
            end
        end
    end

    // Auto-responder for periodic polling.
    bit resp_on = 1'b0;
    initial begin
        rx_auto = 1'b0;
        forever begin
            @(posedge Clk);
            if (resp_on && TxValid && TxReady && TxData == 8'h78) begin
                repeat (10) @(posedge Clk);
                #2 rx_auto = 1'b1;
                repeat (5) @(posedge Clk);
                #2 rx_auto = 1'b0;
            end
        end
    end

    // Saturation run on the small instance.
    bit sat_done = 1'b0;
    initial begin
        s_en = 1'b0;
        wait (RstN === 1'b1);
        @(posedge Clk);
        #2 s_en = 1'b1;
        for (int i = 0; i < 6000 && s_errs < 300; i++) cyc(1);
        s_en = 1'b0;
        chk("sat_300_errors", 32'(s_errs >= 300), 32'd1);
        chk("sat_errcnt_final", 32'(s_errcnt), 32'd255);
        sat_done = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    logic [7:0] want [4];
    int ok0, err0;

    initial begin
        want = '{8'h80, 8'h06, 8'h02, 8'h78};
        RstN = 1'b0; Enable = 1'b0; Trigger = 1'b0;
        TxReady = 1'b1; rx_man = 1'b0;
        cyc(3);
        chk("rst_TxValid", 32'(TxValid), 32'd0);
        chk("rst_TxData", 32'(TxData), 32'd0);
        chk("rst_Busy", 32'(Busy), 32'd0);
        chk("rst_ErrCnt", 32'(ErrCnt), 32'd0);
        RstN = 1'b1;
        cyc(3);

        // Single shot, frame 10 cycles after the command.
        byte_q.delete(); hs_q.delete(); ok0 = ok_cnt; dec_hi = 0;
        Trigger = 1'b1;
        cyc(1);
        Trigger = 1'b0;
        cyc(4);
        cyc(10);
        rx_man = 1'b1;
        cyc(5);
        rx_man = 1'b0;
        cyc(5);
        chk("t1_nbytes", 32'(byte_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("t1_byte", (i < byte_q.size()) ? 32'(byte_q[i])
                : 32'hffff, 32'(want[i]));
        chk("t1_consec", (hs_q.size() == 4) ?
            32'(hs_q[3] - hs_q[0]) : 32'hffff, 32'd3);
        chk("t1_ok", 32'(ok_cnt - ok0), 32'd1);
        chk("t1_dec_cycles", 32'(dec_hi), 32'd5);
        chk("t1_busy_end", 32'(Busy), 32'd0);

        // TxReady toggling during SEND.
        byte_q.delete(); ok0 = ok_cnt;
        TxReady = 1'b1;
        Trigger = 1'b1;
        cyc(1);
        Trigger = 1'b0;
        for (int i = 0; i < 12; i++) begin
            TxReady = ~TxReady;
            cyc(1);
        end
        TxReady = 1'b1;
        cyc(4);
        rx_man = 1'b1;
        cyc(3);
        rx_man = 1'b0;
        cyc(4);
        chk("t2_nbytes", 32'(byte_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("t2_byte", (i < byte_q.size()) ? 32'(byte_q[i])
                : 32'hffff, 32'(want[i]));
        chk("t2_ok", 32'(ok_cnt - ok0), 32'd1);

        // No response: four bursts then an error.
        starts.delete(); err0 = err_cnt;
        Trigger = 1'b1;
        cyc(1);
        Trigger = 1'b0;
        cyc(430);
        chk("t3_bursts", 32'(starts.size()), 32'd4);
        for (int i = 1; i < 4; i++)
            chk("t3_spacing", (i < starts.size()) ?
                32'(starts[i] - starts[i-1]) : 32'hffff, 32'd104);
        chk("t3_err", 32'(err_cnt - err0), 32'd1);
        chk("t3_errcnt", 32'(ErrCnt), 32'd1);
        chk("t3_retry", 32'(RetryCnt), 32'd3);

        // Periodic polling, then drop Enable mid-wait.
        starts.delete(); ok0 = ok_cnt;
        resp_on = 1'b1;
        Enable = 1'b1;
        for (int i = 0; i < 5000 && starts.size() < 4; i++) cyc(1);
        chk("t4_started", 32'(starts.size() >= 4), 32'd1);
        cyc(5);
        Enable = 1'b0;
        cyc(1200);
        resp_on = 1'b0;
        chk("t4_starts", 32'(starts.size()), 32'd4);
        for (int i = 1; i < 4; i++)
            chk("t4_period", (i < starts.size()) ?
                32'(starts[i] - starts[i-1]) : 32'hffff, 32'd1000);
        chk("t4_ok", 32'(ok_cnt - ok0), 32'd4);
        chk("t4_idle", 32'(Busy), 32'd0);

        // Stale frame on entry, unsolicited frame in IDLE.
        dec_hi = 0; ok0 = ok_cnt;
        rx_man = 1'b1;
        cyc(5);
        chk("t5_unsolicited", 32'(dec_hi), 32'd0);
        Trigger = 1'b1;
        cyc(1);
        Trigger = 1'b0;
        cyc(25);
        chk("t5_stale", 32'(ok_cnt - ok0), 32'd0);
        rx_man = 1'b0;
        cyc(3);
        rx_man = 1'b1;
        cyc(3);
        chk("t5_fresh", 32'(ok_cnt - ok0), 32'd1);
        rx_man = 1'b0;
        cyc(5);

        // Frame edge on the timeout cycle: frame wins.
        starts.delete(); ok0 = ok_cnt; err0 = err_cnt;
        cyc(1);
        Trigger = 1'b1;
        cyc(1);
        Trigger = 1'b0;
        cyc(103);
        rx_man = 1'b1;
        cyc(3);
        rx_man = 1'b0;
        cyc(5);
        chk("t6_ok", 32'(ok_cnt - ok0), 32'd1);
        chk("t6_err", 32'(err_cnt - err0), 32'd0);
        chk("t6_bursts", 32'(starts.size()), 32'd1);
        chk("t6_retry", 32'(RetryCnt), 32'd0);

        for (int i = 0; i < 6000 && !sat_done; i++) cyc(1);
        chk("sat_finished", 32'(sat_done), 32'd1);

        // Asynchronous reset while stalled in SEND.
        TxReady = 1'b0;
        Trigger = 1'b1;
        cyc(1);
        Trigger = 1'b0;
        cyc(2);
        chk("t8_pre_valid", 32'(TxValid), 32'd1);
        model_on = 1'b0;
        #1 RstN = 1'b0;
        #1;
        chk("t8_TxValid", 32'(TxValid), 32'd0);
        chk("t8_TxData", 32'(TxData), 32'd0);
        chk("t8_DecDataEn", 32'(DecDataEn), 32'd0);
        chk("t8_Busy", 32'(Busy), 32'd0);
        chk("t8_MeasOk", 32'(MeasOk), 32'd0);
        chk("t8_MeasErr", 32'(MeasErr), 32'd0);
        chk("t8_RetryCnt", 32'(RetryCnt), 32'd0);
        chk("t8_ErrCnt", 32'(ErrCnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
